ofd_bank: RTL

- Parametrised output register bank: the next generation of the team's fixed five-bit output-flop cell.
- Generalised in width, pipeline depth, per-bit init value and per-bit output polarity.
- Adds clock enable, data-valid tracking, synchronous re-init and hold-last-valid output behaviour.
- Sits between core logic and the pad ring; the final stage is the register intended for IOB packing.

---
 rtl/ofd_bank.sv | 73 +++++++
 1 files changed

// File: rtl/ofd_bank.sv
// Parametrised output register bank: DEPTH-stage valid-tracked pipeline whose final
// stage (Q/QV) holds the last valid word and is the register intended for IOB packing.
module ofd_bank #(
    parameter int unsigned      WIDTH  = 5,
    parameter int unsigned      DEPTH  = 1,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter logic [WIDTH-1:0] INVERT = '0
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             SR,
    input  logic             DV,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             QV
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("ofd_bank: WIDTH must be in 1..64");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("ofd_bank: DEPTH must be in 1..8");
    end

    logic [WIDTH-1:0] stage_d_q [DEPTH];
    logic [WIDTH-1:0] stage_d_d [DEPTH];
    logic [DEPTH-1:0] stage_v_q;
    logic [DEPTH-1:0] stage_v_d;

    // Data registers only load behind a valid bit, so bubbles never disturb the
    // last valid word; INVERT is folded in only when entering the last stage.
    always_comb begin
        stage_d_d = stage_d_q;
        stage_v_d = stage_v_q;
        if (CE) begin
            if (SR) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_d_d[i] = INIT;
                end
                stage_v_d = '0;
            end else begin
                stage_v_d[0] = DV;
                if (DV) begin
                    stage_d_d[0] = (DEPTH == 1) ? (D ^ INVERT) : D;
                end
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_v_d[i] = stage_v_q[i-1];
                    if (stage_v_q[i-1]) begin
                        stage_d_d[i] = (i == DEPTH - 1) ? (stage_d_q[i-1] ^ INVERT)
                                                        : stage_d_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_d_q[i] <= INIT;
            end
            stage_v_q <= '0;
        end else begin
            stage_d_q <= stage_d_d;
            stage_v_q <= stage_v_d;
        end
    end

    assign Q  = stage_d_q[DEPTH-1];
    assign QV = stage_v_q[DEPTH-1];

endmodule
